vending_machine: RTL and testbench
==================================

// Module: vending_machine
// PURPOSE
//   Coin-accepting controller for a single-product vending machine priced at 15 Rs.
//   Accepts 5 Rs and 10 Rs coins, one coin code per clock. Dispenses the product
//   when accumulated credit reaches 15 Rs and returns any excess as change.
//   Refunds credit when a cycle passes with no coin.
//   Sits between the coin-validator front end and the dispense/refund actuators.
// PARAMETERS
//   none -- price (15 Rs) and coin values (5/10 Rs) are fixed.
//   State encoding uses localparams S0=2'd0, S5=2'd1, S10=2'd2.
// PORTS
//   clk     input   1  system clock; all state changes on the rising edge
//   rst     input   1  asynchronous reset, active-low (0 = reset)
//   in      input   2  coin code sampled each rising edge:
//                      00 = no coin, 01 = 5 Rs, 10 = 10 Rs, 11 = invalid
//   out     output  1  dispense pulse; 1 for exactly one cycle per sale
//   change  output  2  change returned: 00 = none, 01 = 5 Rs, 10 = 10 Rs; 11 never driven
// BEHAVIOUR
//   - Asserting rst (low) immediately forces state=S0, out=0, change=00, independent of clk.
//   - Reset mid-transaction discards credit; no refund is issued.
//   - While rst is low the FSM holds S0; first active edge after release samples in.
//   - state = credit held (S0=0, S5=5, S10=10 Rs). out/change are registered.
//   - out/change are updated on the same edge as the state transition and held for
//     one cycle; they are 0/00 on any edge not listed below as producing them.
//   - Transition table (state, in -> next, out, change):
//       S0 ,00 -> S0 ,0,00   S0 ,01 -> S5 ,0,00   S0 ,10 -> S10,0,00
//       S5 ,00 -> S0 ,0,01   S5 ,01 -> S10,0,00   S5 ,10 -> S0 ,1,00
//       S10,00 -> S0 ,0,10   S10,01 -> S0 ,1,00   S10,10 -> S0 ,1,01
//   - in=00 with nonzero credit is a timeout: full credit is refunded via change.
//   - in=11 in any state: state held, out=0, change=00. This is not a timeout and
//     not a coin.
//   - Credit never exceeds 10 Rs between edges. Max single-edge total is 20 Rs
//     (S10 + 10 Rs), giving a sale plus 5 Rs change.
//   - Illegal state encoding 2'd3 recovers to S0 on the next edge with out=0, change=00.
//   - Latency: a sale or refund is visible on out/change after the edge that samples
//     the completing coin, i.e. zero extra cycles after that edge.
// TESTING
//   1. rst=0 for 2 cycles, then release with in=00
//      -> out=0, change=00, state S0 throughout.
//   2. 01, then 10 on consecutive edges
//      -> after edge 2: out=1, change=00; next edge with 00: out=0, state S0.
//   3. 10, then 10
//      -> after edge 2: out=1, change=01 (5 Rs back), state S0.
//   4. 01, then 01, then 01
//      -> S5, S10, then out=1, change=00.
//   5. 10, then 00
//      -> after edge 2: out=0, change=10 (10 Rs refund).
//      Also 01, then 00 -> change=01.
//   6. 01, then 11, then 10
//      -> 11 holds S5 with no outputs; then out=1.
//      Separately: drive rst low asynchronously in S10 -> out=0, change=00 at once, credit lost.

Source files
------------

// File: rtl/vending_machine_if.sv
`default_nettype none
// ============================================================================
// Module      : vending_machine_if
// Description : Coin-code and dispense/change bundle between the coin
//               validator (master) and the vending controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface vending_machine_if;
    logic [1:0] in;      // coin code: 00 none, 01 5 Rs, 10 10 Rs, 11 invalid
    logic       out;     // one-cycle dispense pulse
    logic [1:0] change;  // change returned: 00 none, 01 5 Rs, 10 10 Rs

    modport master (output in, input  out, input  change);
    modport slave  (input  in, output out, output change);
endinterface
`default_nettype wire

// File: rtl/vending_machine.sv
`default_nettype none
// ============================================================================
// Module      : vending_machine
// Description : 15 Rs single-product vending controller. Accepts 5/10 Rs
//               coins, dispenses on reaching 15 Rs, returns excess as change
//               and refunds held credit when a cycle passes with no coin.
// Revision    : 1.0 - initial release
// ============================================================================
module vending_machine (
    input  wire               clk,
    input  wire               rst,    // asynchronous, active-low
    vending_machine_if.slave  bus
);

    // Coin codes
    localparam logic [1:0] c_COIN_NONE = 2'b00;
    localparam logic [1:0] c_COIN_5    = 2'b01;
    localparam logic [1:0] c_COIN_10   = 2'b10;

    // Change codes
    localparam logic [1:0] c_CHG_NONE  = 2'b00;
    localparam logic [1:0] c_CHG_5     = 2'b01;
    localparam logic [1:0] c_CHG_10    = 2'b10;

    // State equals the credit currently held; 2'd3 is unreachable and
    // recovers to S0.
    typedef enum logic [1:0] {
        S0    = 2'd0,
        S5    = 2'd1,
        S10   = 2'd2,
        S_ILL = 2'd3
    } state_t;

    state_t     r_state;
    logic       r_out;
    logic [1:0] r_change;

    state_t     w_next_state;
    logic       w_next_out;
    logic [1:0] w_next_change;

    // Register state and outputs together so a sale or refund appears on
    // the same edge that samples the completing coin.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S0;
            r_out    <= 1'b0;
            r_change <= c_CHG_NONE;
        end else begin
            r_state  <= w_next_state;
            r_out    <= w_next_out;
            r_change <= w_next_change;
        end
    end

    // Next-state and next-output decode; invalid coin code 11 holds credit.
    always_comb begin
        w_next_state  = r_state;
        w_next_out    = 1'b0;
        w_next_change = c_CHG_NONE;
        case (r_state)
            S0: begin
                case (bus.in)
                    c_COIN_5:  w_next_state = S5;
                    c_COIN_10: w_next_state = S10;
                    default:   w_next_state = S0;
                endcase
            end
            S5: begin
                case (bus.in)
                    c_COIN_NONE: begin
                        w_next_state  = S0;
                        w_next_change = c_CHG_5;
                    end
                    c_COIN_5:  w_next_state = S10;
                    c_COIN_10: begin
                        w_next_state = S0;
                        w_next_out   = 1'b1;
                    end
                    default:   w_next_state = S5;
                endcase
            end
            S10: begin
                case (bus.in)
                    c_COIN_NONE: begin
                        w_next_state  = S0;
                        w_next_change = c_CHG_10;
                    end
                    c_COIN_5: begin
                        w_next_state = S0;
                        w_next_out   = 1'b1;
                    end
                    c_COIN_10: begin
                        w_next_state  = S0;
                        w_next_out    = 1'b1;
                        w_next_change = c_CHG_5;
                    end
                    default:   w_next_state = S10;
                endcase
            end
            default: begin
                w_next_state = S0;
            end
        endcase
    end

    assign bus.out    = r_out;
    assign bus.change = r_change;

endmodule
`default_nettype wire

// File: tb/tb_vending_machine.sv
`default_nettype none
// ============================================================================
// Module      : tb_vending_machine
// Description : Directed self-checking bench for vending_machine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vending_machine;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    vending_machine_if vif ();

    vending_machine dut (
        .clk (clk),
        .rst (rst),
        .bus (vif.slave)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare the three observable quantities against hand-computed values.
    task automatic check(input string tag, input logic exp_out,
                         input logic [1:0] exp_chg, input logic [1:0] exp_st);
        n_vec++;
        assert (vif.out === exp_out) else begin
            n_bad++;
            $error("FAIL %s out: got %b want %b", tag, vif.out, exp_out);
        end
        n_vec++;
        assert (vif.change === exp_chg) else begin
            n_bad++;
            $error("FAIL %s change: got %b want %b", tag, vif.change, exp_chg);
        end
        n_vec++;
        assert (2'(dut.r_state) === exp_st) else begin
            n_bad++;
            $error("FAIL %s state: got %0d want %0d", tag, 2'(dut.r_state), exp_st);
        end
    endtask

    // Drive a coin code, let one rising edge sample it, then check 1 ns later.
    task automatic step(input logic [1:0] coin, input string tag, input logic exp_out,
                        input logic [1:0] exp_chg, input logic [1:0] exp_st);
        vif.in = coin;
        @(posedge clk);
        #1;
        check(tag, exp_out, exp_chg, exp_st);
    endtask

    initial begin
        n_vec  = 0;
        n_bad  = 0;
        vif.in = 2'b00;
        rst    = 1'b0;

        // 1. Reset held for two cycles, then release with no coin
        @(posedge clk); #1;
        check("rst_c1", 1'b0, 2'b00, 2'd0);
        @(posedge clk); #1;
        check("rst_c2", 1'b0, 2'b00, 2'd0);
        rst = 1'b1;
        step(2'b00, "idle", 1'b0, 2'b00, 2'd0);

        // 2. 5 then 10 -> sale, exact price
        step(2'b01, "t2_5",   1'b0, 2'b00, 2'd1);
        step(2'b10, "t2_10",  1'b1, 2'b00, 2'd0);
        step(2'b00, "t2_idl", 1'b0, 2'b00, 2'd0);

        // 3. 10 then 10 -> sale plus 5 Rs change
        step(2'b10, "t3_10a", 1'b0, 2'b00, 2'd2);
        step(2'b10, "t3_10b", 1'b1, 2'b01, 2'd0);

        // 4. 5, 5, 5 -> sale
        step(2'b01, "t4_5a",  1'b0, 2'b00, 2'd1);
        step(2'b01, "t4_5b",  1'b0, 2'b00, 2'd2);
        step(2'b01, "t4_5c",  1'b1, 2'b00, 2'd0);

        // 5. Timeout refunds: 10 then none, 5 then none
        step(2'b10, "t5_10",  1'b0, 2'b00, 2'd2);
        step(2'b00, "t5_r10", 1'b0, 2'b10, 2'd0);
        step(2'b01, "t5_5",   1'b0, 2'b00, 2'd1);
        step(2'b00, "t5_r5",  1'b0, 2'b01, 2'd0);

        // 6. Invalid code holds credit without outputs
        step(2'b01, "t6_5",   1'b0, 2'b00, 2'd1);
        step(2'b11, "t6_inv", 1'b0, 2'b00, 2'd1);
        step(2'b10, "t6_10",  1'b1, 2'b00, 2'd0);
        step(2'b11, "t6_inv0",1'b0, 2'b00, 2'd0);

        // S10 + 5 -> sale, no change; invalid in S10 holds
        step(2'b10, "s10",    1'b0, 2'b00, 2'd2);
        step(2'b11, "s10_inv",1'b0, 2'b00, 2'd2);
        step(2'b01, "s10_5",  1'b1, 2'b00, 2'd0);

        // Asynchronous reset in S10: credit lost, no refund afterwards
        step(2'b10, "ar_10",  1'b0, 2'b00, 2'd2);
        #2 rst = 1'b0;
        #1;
        check("ar_s10", 1'b0, 2'b00, 2'd0);
        vif.in = 2'b00;
        @(posedge clk); #1;
        check("ar_hold", 1'b0, 2'b00, 2'd0);
        rst = 1'b1;
        step(2'b00, "ar_norf", 1'b0, 2'b00, 2'd0);

        // Asynchronous reset while a sale pulse is high clears it at once
        step(2'b10, "ar2_10a", 1'b0, 2'b00, 2'd2);
        step(2'b10, "ar2_10b", 1'b1, 2'b01, 2'd0);
        #2 rst = 1'b0;
        #1;
        check("ar2_clr", 1'b0, 2'b00, 2'd0);
        rst = 1'b1;
        step(2'b01, "post_5", 1'b0, 2'b00, 2'd1);
        step(2'b00, "post_r", 1'b0, 2'b01, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Absolute bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
